// File: rtl/mem_arbiter_pkg.sv
// Shared defines for the memory arbiter: bus widths, stall-bus bit positions,
// FSM state encodings and load/store width codes.
package mem_arbiter_pkg;

    localparam int ADDR_LEN = 32;
    localparam int BYTE_LEN = 8;
    localparam int DATA_LEN = 32;
    localparam int CNT_LEN  = 3;

    // Stall bus: bit positions of the per-requester busy lines
    localparam int STALL_LEN = 2;
    localparam int STALL_IF  = 0;
    localparam int STALL_MEM = 1;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RD   = 2'b01;
    localparam logic [1:0] ST_WR   = 2'b10;

    // Load/store width codes (11 aliases a full word)
    localparam logic [1:0] WIDTH_B  = 2'b00;
    localparam logic [1:0] WIDTH_H  = 2'b01;
    localparam logic [1:0] WIDTH_W  = 2'b10;
    localparam logic [1:0] WIDTH_W2 = 2'b11;

    // Byte count for a width code
    function automatic logic [CNT_LEN-1:0] width_len(input logic [1:0] w);
        case (w)
            WIDTH_B: return 3'd1;
            WIDTH_H: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter between the instruction-fetch port and the load/store
// port onto a single byte-wide RAM with one-cycle read latency.
// Fixed priority (mem wins), non-preemptive, one-cycle bubble after each done.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                io_buffer_full,
    input  logic                if_req,
    input  logic [ADDR_LEN-1:0] if_addr,
    output logic                if_done,
    output logic [DATA_LEN-1:0] if_inst,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [1:0]          mem_width,
    input  logic [ADDR_LEN-1:0] mem_addr,
    input  logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_done,
    output logic [DATA_LEN-1:0] mem_rdata,
    input  logic [BYTE_LEN-1:0] ram_din,
    output logic [BYTE_LEN-1:0] ram_dout,
    output logic [ADDR_LEN-1:0] ram_a,
    output logic                ram_wr,
    output logic                busy_if,
    output logic                busy_mem
);

    logic [1:0]          state;
    logic [CNT_LEN-1:0]  cnt;
    logic [CNT_LEN-1:0]  len;
    logic [ADDR_LEN-1:0] base;
    logic [DATA_LEN-1:0] wdata_q;
    logic                sel_mem;
    logic [DATA_LEN-1:0] rd_buf;
    logic [DATA_LEN-1:0] rd_next;
    logic                rdy_q;
    logic [BYTE_LEN-1:0] din_hold;
    logic [BYTE_LEN-1:0] din_eff;

    assign busy_if  = if_req & ~if_done;
    assign busy_mem = mem_req & ~mem_done;

    assign ram_a  = (state == ST_IDLE) ? '0 : base + {{(ADDR_LEN-CNT_LEN){1'b0}}, cnt};
    assign ram_wr = (state == ST_WR) & rdy_in & ~io_buffer_full;

    // The RAM keeps reading while we are frozen, so ram_din only belongs to
    // byte cnt-1 in the cycle right after an active one; otherwise use the
    // byte snapshotted on the first frozen cycle.
    assign din_eff = rdy_q ? ram_din : din_hold;

    // Byte lane of the latched store data selected by the byte counter
    always_comb begin
        ram_dout = '0;
        if (state == ST_WR) begin
            case (cnt[1:0])
                2'd0:    ram_dout = wdata_q[7:0];
                2'd1:    ram_dout = wdata_q[15:8];
                2'd2:    ram_dout = wdata_q[23:16];
                default: ram_dout = wdata_q[31:24];
            endcase
        end
    end

    // Merge the returning byte (cnt-1) into the little-endian read buffer
    always_comb begin
        rd_next = rd_buf;
        case (cnt)
            3'd1:    rd_next[7:0]   = din_eff;
            3'd2:    rd_next[15:8]  = din_eff;
            3'd3:    rd_next[23:16] = din_eff;
            3'd4:    rd_next[31:24] = din_eff;
            default: ;
        endcase
    end

    // Track freeze edges and hold the last fresh RAM byte across a freeze
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rdy_q    <= 1'b0;
            din_hold <= '0;
        end else begin
            rdy_q    <= rdy_in;
            din_hold <= din_eff;
        end
    end

    // Arbitration FSM, byte counter, latched request and done/data outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            len       <= '0;
            base      <= '0;
            wdata_q   <= '0;
            sel_mem   <= 1'b0;
            rd_buf    <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_inst   <= '0;
            mem_rdata <= '0;
        end else if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    if_done  <= 1'b0;
                    mem_done <= 1'b0;
                    cnt      <= '0;
                    // no accept while a done pulse is showing: requester
                    // still sees its old req high in that cycle
                    if (!if_done && !mem_done) begin
                        if (mem_req) begin
                            state   <= mem_we ? ST_WR : ST_RD;
                            base    <= mem_addr;
                            len     <= width_len(mem_width);
                            wdata_q <= mem_wdata;
                            sel_mem <= 1'b1;
                            rd_buf  <= '0;
                        end else if (if_req) begin
                            state   <= ST_RD;
                            base    <= if_addr;
                            len     <= 3'd4;
                            wdata_q <= '0;
                            sel_mem <= 1'b0;
                            rd_buf  <= '0;
                        end
                    end
                end
                ST_RD: begin
                    rd_buf <= rd_next;
                    cnt    <= cnt + 3'd1;
                    if (cnt == len) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        if (sel_mem) begin
                            mem_rdata <= rd_next;
                            mem_done  <= 1'b1;
                        end else begin
                            if_inst <= rd_next;
                            if_done <= 1'b1;
                        end
                    end
                end
                ST_WR: begin
                    if (!io_buffer_full) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == len - 3'd1) begin
                            state    <= ST_IDLE;
                            cnt      <= '0;
                            mem_done <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk_in  in  1  sole clock, rising edge.
REQ-002 SHALL have rst_in  in  1  asynchronous, active-low reset.
REQ-003 SHALL have rdy_in  in  1  global enable; low = freeze.
REQ-004 SHALL have io_buffer_full  in  1  high = no RAM write byte may issue.
REQ-005 SHALL have if_req  in  1, if_addr  in  32, if_done  out  1, if_inst  out  32: instruction fetch port, 4 bytes.
REQ-006 SHALL have mem_req  in  1, mem_we  in  1, mem_width  in  2, mem_addr  in  32, mem_wdata  in  32, mem_done  out  1, mem_rdata  out  32: load/store port.
REQ-007 SHALL have ram_din  in  8, ram_dout  out  8, ram_a  out  32, ram_wr  out  1: byte-wide RAM, 1-cycle read latency.
REQ-008 SHALL have busy_if  out  1 = if_req & ~if_done, busy_mem  out  1 = mem_req & ~mem_done, both combinational; they drive the stall bus req_if/req_mem.

Function
REQ-009 mem_width SHALL encode 00=1 byte, 01=2, 10=4, 11=4; N denotes the byte count.
REQ-010 FSM states SHALL be IDLE, RD, WR; byte counter cnt is 3 bits.
REQ-011 In IDLE with both requests high, mem SHALL win (fixed priority); the winner's address, width, wdata and port id SHALL be latched; cnt=0.
REQ-012 Arbitration SHALL be non-preemptive; a started transaction SHALL complete even if its req drops.
REQ-013 No request SHALL be accepted in a cycle where if_done or mem_done is high (one-cycle bubble).
REQ-014 RD: cycles cnt=0..N-1 SHALL drive ram_a=base+cnt; cycles cnt=1..N SHALL capture ram_din into byte cnt-1 (little-endian); after the cnt=N cycle, return to IDLE.
REQ-015 The read result SHALL be zero-extended to 32 bits and presented on if_inst/mem_rdata with a one-cycle done pulse the cycle after the cnt=N cycle; data SHALL hold until the next completion.
REQ-016 WR: each cycle with io_buffer_full low SHALL drive ram_wr=1, ram_a=base+cnt, ram_dout=byte cnt, then increment cnt; with io_buffer_full high, ram_wr=0 and cnt SHALL hold.
REQ-017 WR SHALL return to IDLE after byte N-1 issues, with mem_done pulsing the following cycle.
REQ-018 Fetch requests SHALL always be reads, N=4.
REQ-019 rdy_in low SHALL freeze all state, counters and done pulses (held, not lost) and force ram_wr=0; no RAM byte is issued or captured.
REQ-020 ram_wr SHALL be 0 in IDLE and RD.
REQ-021 Address arithmetic SHALL be 32-bit modulo 2^32 (wraps at 0xFFFFFFFF).

Reset
REQ-022 While rst_in is low, the FSM SHALL be IDLE with cnt=0, ram_a=0, ram_dout=0, ram_wr=0, if_done=0, mem_done=0, if_inst=0, mem_rdata=0.
REQ-023 Reset asserted mid-transaction SHALL abort it with no done pulse; the requester re-issues the request.

Structure
REQ-024 FSM state encodings, width codes and AddrLen/ByteLen SHALL live in the shared defines file beside the stall-level constants.
REQ-025 The block SHALL be a single module; no sub-module.

Verification
REQ-026 Fetch: if_req=1, if_addr=0x100, RAM bytes 13 05 00 00 -> if_done pulses 6 cycles after acceptance, if_inst=0x00000513.
REQ-027 Contention: if_req and mem_req (load, width 10, addr 0x200) in the same cycle -> mem serviced first, then 1-cycle bubble, then fetch; if_done follows mem_done.
REQ-028 Store byte: mem_we=1, width 00, addr 0x30000, wdata 0x41, io_buffer_full high 3 cycles -> ram_wr stays 0 for 3 cycles, then one write of 0x41, mem_done next cycle.
REQ-029 rdy_in low for 2 cycles in RD of a halfword load at 0xFFFFFFFF -> ram_a sequence 0xFFFFFFFF, 0x00000000, result correct, done delayed by exactly 2 cycles.
REQ-030 Reset pulse in WR after byte 1 of a word store -> all outputs zero, no mem_done, next accepted request runs normally.
